// File: rtl/clock_pkg.sv
// Shared definitions for the clock ratio meter: FSM encoding, synchronizer depth,
// default counter width and the half-period to ratio conversion.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        TOUT = 2'd2
    } meter_state_t;

    localparam int SYNC_STAGES   = 2;
    localparam int DEFAULT_CNT_W = 16;

    // Divider convention: a half-period of H fast cycles is programmed as H-1.
    function automatic logic [31:0] ratio_of(input logic [31:0] h);
        return h - 32'd1;
    endfunction

endpackage

// File: rtl/clock_sync_edge.sv
// Multi-flop synchronizer for an asynchronous clock input followed by an edge
// detector; RISE_ONLY=1 restricts the edge pulse to rising transitions.
module clock_sync_edge
    import clock_pkg::*;
#(
    parameter bit RISE_ONLY = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign edge_o  = RISE_ONLY ? (sync_q[SYNC_STAGES-1] & ~prev_q)
                               : (sync_q[SYNC_STAGES-1] ^ prev_q);

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures the divide ratio of Slow_Clock in Fast_Clock cycles and hands it out
// over Valid/Ack. Define CLOCK_RATIO_METER_FULL_PERIOD_EN to time full periods.
module clock_ratio_meter
    import clock_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int LOCK_CNT = 2
) (
    input  logic             Fast_Clock,
    input  logic             Reset,
    input  logic             Slow_Clock,
    input  logic             Ack,
    output logic [CNT_W-1:0] Ratio,
    output logic             Valid,
    output logic             Overrun,
    output logic             Timeout,
`ifdef CLOCK_RATIO_METER_FULL_PERIOD_EN
    output logic             Ratio_Odd,
`endif
    output logic             Locked
);

    localparam int               MATCH_W = $clog2(LOCK_CNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_M = MATCH_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef CLOCK_RATIO_METER_FULL_PERIOD_EN
    localparam bit RISE_ONLY = 1'b1;
`else
    localparam bit RISE_ONLY = 1'b0;
`endif

    meter_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ratio_q, ratio_d;
    logic [CNT_W-1:0]   prev_h_q, prev_h_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               term_edge;
    logic               slow_level_unused;
    logic               publish;
    logic               to_timeout;
    logic [CNT_W-1:0]   h_eff;
    logic [31:0]        ratio_full;
    logic [CNT_W-1:0]   ratio_new;
    logic               ratio_hi_unused;

    clock_sync_edge #(
        .RISE_ONLY(RISE_ONLY)
    ) u_sync (
        .clk_i  (Fast_Clock),
        .rst_ni (Reset),
        .async_i(Slow_Clock),
        .level_o(slow_level_unused),
        .edge_o (term_edge)
    );

`ifdef CLOCK_RATIO_METER_FULL_PERIOD_EN
    // A full period is two half-periods; the dropped LSB is reported separately.
    assign h_eff = {1'b0, cnt_q[CNT_W-1:1]};
`else
    assign h_eff = cnt_q;
`endif

    assign ratio_full      = ratio_of(32'(h_eff));
    assign ratio_new       = ratio_full[CNT_W-1:0];
    assign ratio_hi_unused = ^ratio_full[31:CNT_W];

    // Interval FSM and counter
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        publish    = 1'b0;
        to_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (term_edge) begin
                    state_d = MEAS;
                    cnt_d   = CNT_ONE;
                end
            end
            MEAS: begin
                if (term_edge) begin
                    publish = 1'b1;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d    = TOUT;
                    to_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            TOUT: begin
                if (term_edge) begin
                    state_d = MEAS;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Result register, handshake and lock tracking
    always_comb begin
        ratio_d   = ratio_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        prev_h_d  = prev_h_q;
        match_d   = match_q;
        if (publish) begin
            ratio_d  = ratio_new;
            valid_d  = 1'b1;
            prev_h_d = cnt_q;
            if (valid_q && !Ack) begin
                overrun_d = 1'b1;
            end
            if (cnt_q == prev_h_q) begin
                match_d = (match_q >= LOCK_M) ? LOCK_M : match_q + MATCH_W'(1);
            end else begin
                match_d = MATCH_W'(1);
            end
        end else if (valid_q && Ack) begin
            valid_d = 1'b0;
        end
        if (to_timeout) begin
            match_d = '0;
        end
    end

    always_ff @(posedge Fast_Clock) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ratio_q   <= '0;
            prev_h_q  <= '0;
            match_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            prev_h_q  <= prev_h_d;
            match_q   <= match_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef CLOCK_RATIO_METER_FULL_PERIOD_EN
    logic odd_q;

    always_ff @(posedge Fast_Clock) begin
        if (!Reset) begin
            odd_q <= 1'b0;
        end else if (publish) begin
            odd_q <= cnt_q[0];
        end
    end

    assign Ratio_Odd = odd_q;
`endif

    assign Ratio   = ratio_q;
    assign Valid   = valid_q;
    assign Overrun = overrun_q;
    assign Timeout = (state_q == TOUT);
    assign Locked  = (match_q >= LOCK_M);

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Self-checking bench for clock_ratio_meter: table-driven steady toggling with a
// scoreboard of expected publishes, plus hand sequences for the corner cases.
module tb_clock_ratio_meter;

`ifdef CLOCK_RATIO_METER_FULL_PERIOD_EN
    localparam bit FULL = 1'b1;
    localparam int TE   = 2;
`else
    localparam bit FULL = 1'b0;
    localparam int TE   = 1;
`endif
    localparam int MAX16 = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slow16 = 1'b0;
    logic        ack16 = 1'b1;
    logic        slow4 = 1'b0;
    logic        ack4 = 1'b1;
    logic [15:0] ratio16;
    logic        valid16, overrun16, timeout16, locked16;
    logic [3:0]  ratio4;
    logic        valid4, overrun4, timeout4, locked4;
`ifdef CLOCK_RATIO_METER_FULL_PERIOD_EN
    logic        odd16, odd4;
`endif

    always #5 clk = ~clk;

    clock_ratio_meter #(.CNT_W(16), .LOCK_CNT(2)) dut16 (
        .Fast_Clock(clk), .Reset(rst_n), .Slow_Clock(slow16), .Ack(ack16),
        .Ratio(ratio16), .Valid(valid16), .Overrun(overrun16), .Timeout(timeout16),
`ifdef CLOCK_RATIO_METER_FULL_PERIOD_EN
        .Ratio_Odd(odd16),
`endif
        .Locked(locked16)
    );

    clock_ratio_meter #(.CNT_W(4), .LOCK_CNT(2)) dut4 (
        .Fast_Clock(clk), .Reset(rst_n), .Slow_Clock(slow4), .Ack(ack4),
        .Ratio(ratio4), .Valid(valid4), .Overrun(overrun4), .Timeout(timeout4),
`ifdef CLOCK_RATIO_METER_FULL_PERIOD_EN
        .Ratio_Odd(odd4),
`endif
        .Locked(locked4)
    );

    typedef struct {
        int ratio;
        int locked;
        int odd;
    } exp_t;

    typedef struct {
        int hi;
        int lo;
        int periods;
        int exp_ratio;
        int exp_locked;
    } vec_t;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    bit   mon_en = 1'b0;
    int   mon_seen = 0;
    int   pubs4 = 0;
    bit   armed = 1'b0;
    int   last_edge = 0;
    int   prev_h = 0;
    int   match = 0;
    int   model_pubs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        armed = 1'b0;
        last_edge = 0;
        prev_h = 0;
        match = 0;
        sb_q.delete();
    endtask

    // Reference: the interval between two terminating edges, measured in fast cycles.
    task automatic model_edge();
        int   gap;
        exp_t e;
        gap = cyc - last_edge;
        if (armed) begin
            if (gap <= MAX16) begin
                e.ratio  = FULL ? (gap / 2) - 1 : gap - 1;
                e.odd    = FULL ? (gap % 2) : 0;
                match    = (gap == prev_h) ? ((match >= 2) ? 2 : match + 1) : 1;
                prev_h   = gap;
                e.locked = (match >= 2) ? 1 : 0;
                sb_q.push_back(e);
                model_pubs++;
            end else begin
                match = 0;
            end
        end
        armed = 1'b1;
        last_edge = cyc;
    endtask

    task automatic toggle16();
        slow16 = ~slow16;
        if (!FULL || slow16) model_edge();
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (valid16 && ack16) mon_seen++;
            if (valid4 && ack4) pubs4++;
            if (mon_en && valid16 && ack16) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_publish", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    $display("publish ratio=%0d locked=%0d (exp %0d/%0d)",
                             ratio16, locked16, e.ratio, e.locked);
                    check("sb_ratio", int'(ratio16), e.ratio);
                    check("sb_locked", int'(locked16), e.locked);
`ifdef CLOCK_RATIO_METER_FULL_PERIOD_EN
                    check("sb_odd", int'(odd16), e.odd);
`endif
                end
            end
        end
    endtask

    task automatic do_reset(input string tag);
        mon_en = 1'b0;
        slow16 = 1'b0;
        wait_cyc(4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ratio"}, int'(ratio16), 0);
        check({tag, "_valid"}, int'(valid16), 0);
        check({tag, "_overrun"}, int'(overrun16), 0);
        check({tag, "_timeout"}, int'(timeout16), 0);
        check({tag, "_locked"}, int'(locked16), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t vecs[3];

    initial begin
        int target;
        int seen0;
        int p0;
`ifdef CLOCK_RATIO_METER_FULL_PERIOD_EN
        vecs[0] = '{hi: 6,  lo: 6,  periods: 4, exp_ratio: 5, exp_locked: 1};
        vecs[1] = '{hi: 10, lo: 10, periods: 3, exp_ratio: 9, exp_locked: 1};
        vecs[2] = '{hi: 6,  lo: 7,  periods: 3, exp_ratio: 5, exp_locked: 1};
`else
        vecs[0] = '{hi: 6,  lo: 6,  periods: 4, exp_ratio: 5, exp_locked: 1};
        vecs[1] = '{hi: 10, lo: 10, periods: 3, exp_ratio: 9, exp_locked: 1};
        vecs[2] = '{hi: 6,  lo: 7,  periods: 3, exp_ratio: 5, exp_locked: 0};
`endif
        fork
            monitor_loop();
        join_none

        // Steady toggling with Ack held high, scoreboard checks every publish
        do_reset("reset");
        ack16 = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < vecs[i].periods; p++) begin
                toggle16();
                wait_cyc(vecs[i].hi);
                toggle16();
                wait_cyc(vecs[i].lo);
            end
            wait_cyc(2);
            $display("segment %0d hi=%0d lo=%0d ratio=%0d locked=%0d", i, vecs[i].hi,
                     vecs[i].lo, ratio16, locked16);
            check($sformatf("seg%0d_ratio", i), int'(ratio16), vecs[i].exp_ratio);
            check($sformatf("seg%0d_locked", i), int'(locked16), vecs[i].exp_locked);
        end
        check("sb_drain_steady", sb_q.size(), 0);

        // Ack held low: first result holds, second overwrites and flags Overrun
        do_reset("reset2");
        ack16 = 1'b0;
        target = model_pubs + 1;
        for (int k = 0; k < 8 && model_pubs < target; k++) begin
            toggle16();
            wait_cyc(6);
        end
        check("hold_valid", int'(valid16), 1);
        check("hold_ratio", int'(ratio16), 5);
        check("hold_no_overrun", int'(overrun16), 0);
        target = model_pubs + 1;
        for (int k = 0; k < 8 && model_pubs < target; k++) begin
            toggle16();
            wait_cyc(6);
        end
        check("ovr_valid", int'(valid16), 1);
        check("ovr_flag", int'(overrun16), 1);
        check("ovr_ratio", int'(ratio16), 5);
        ack16 = 1'b1;
        @(posedge clk);
        #1;
        check("ack_clears_valid", int'(valid16), 0);
        check("overrun_sticky", int'(overrun16), 1);
        $display("ack released valid=%0d overrun=%0d", valid16, overrun16);

        // Reset pulse in the middle of an interval
        do_reset("reset3");
        ack16 = 1'b1;
        mon_en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            toggle16();
            wait_cyc(6);
            toggle16();
            wait_cyc(6);
        end
        toggle16();
        wait_cyc(6);
        toggle16();
        wait_cyc(4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ratio", int'(ratio16), 0);
        check("midrst_valid", int'(valid16), 0);
        check("midrst_locked", int'(locked16), 0);
        check("midrst_overrun", int'(overrun16), 0);
        check("midrst_sb_empty", sb_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen0 = mon_seen;
        for (int k = 0; k < TE; k++) begin
            toggle16();
            wait_cyc(6);
        end
        check("midrst_no_pub_first_edge", mon_seen - seen0, 0);
        for (int k = 0; k < TE; k++) begin
            toggle16();
            wait_cyc(6);
        end
        check("midrst_one_pub_second_edge", mon_seen - seen0, 1);
        check("midrst_ratio_after", int'(ratio16), 5);
        check("sb_drain_midrst", sb_q.size(), 0);
        mon_en = 1'b0;

        // Narrow counter: stopped input saturates and times out
        for (int k = 0; k < 8; k++) begin
            slow4 = ~slow4;
            wait_cyc(6);
        end
        check("t4_locked_before", int'(locked4), 1);
        check("t4_timeout_before", int'(timeout4), 0);
        wait_cyc(20);
        $display("cnt4 stopped timeout=%0d locked=%0d", timeout4, locked4);
        check("t4_timeout", int'(timeout4), 1);
        check("t4_unlocked", int'(locked4), 0);
        p0 = pubs4;
        for (int k = 0; k < TE; k++) begin
            slow4 = ~slow4;
            wait_cyc(6);
        end
        check("t4_no_pub_first_edge", pubs4 - p0, 0);
        check("t4_timeout_cleared", int'(timeout4), 0);
        for (int k = 0; k < TE; k++) begin
            slow4 = ~slow4;
            wait_cyc(6);
        end
        $display("cnt4 restart pubs=%0d ratio=%0d", pubs4 - p0, ratio4);
        check("t4_one_pub", pubs4 - p0, 1);
        check("t4_ratio", int'(ratio4), 5);
        check("t4_locked_after", int'(locked4), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_ratio_meter.md
Name: clock_ratio_meter

Overview:
- Fast-domain monitor that recovers the divide ratio of a divided clock.
- Counts Fast_Clock cycles between transitions of an incoming Slow_Clock and reports the ratio in the same N_COUNT convention the clock divider uses.
- Ratio = half-period − 1.
- Used for board bring-up and self-check of the processor clock tree; results are delivered over a Valid/Ack handshake.

Parameters:
- CNT_W, 16: width of the interval counter and Ratio output.
- LOCK_CNT, 2: number of consecutive identical measurements required to assert Locked.

Ports:
- Fast_Clock  in  1  reference clock; all logic on posedge.
- Reset  in  1  synchronous, active-low reset; Reset==0 at a posedge resets the block.
- Slow_Clock  in  1  measured clock, asynchronous to Fast_Clock.
- Ack  in  1  consumer accepts Ratio when Valid && Ack at a posedge.
- Ratio  out  CNT_W  last measured half-period minus 1.
- Valid  out  1  Ratio holds an unconsumed measurement.
- Overrun  out  1  sticky: a new measurement replaced an unconsumed one.
- Timeout  out  1  the current interval saturated the counter.
- Locked  out  1  last LOCK_CNT measurements were identical.

Behaviour:
- Reset (Reset==0):
  - Ratio=0, Valid=0, Overrun=0, Timeout=0, Locked=0.
  - Synchronizer flops cleared to 0.
  - State=IDLE, counter=0, match count=0.
  - Reset mid-interval discards the partial interval; there is no output until two edges after release.
- Input path:
  - Two-flop synchronizer, then one edge-detect register.
  - edge = sync2 XOR prev.
  - An input transition sampled at posedge k yields edge=1 in cycle k+2.
- Counter:
  - Increments every cycle while in MEAS.
  - Cleared to 1 on the cycle edge=1.
  - Half-period H = counter value at edge.
  - Steady input toggling every T fast cycles gives H=T.
- IDLE:
  - Waits for the first edge (partial interval).
  - edge -> MEAS, counter=1, nothing published.
- MEAS:
  - On edge: publish Ratio=H−1 and Valid=1 on the next posedge, so Valid rises 3 cycles after sampling; counter restarts at 1.
  - If counter reaches 2^CNT_W−1 without an edge: go to TOUT, Timeout=1, Locked=0, match count=0.
- TOUT:
  - Counter is held.
  - On edge: Timeout=0 -> MEAS, counter=1, no publish (interval invalid).
- Handshake:
  - Valid stays high with Ratio stable until Valid && Ack.
  - Valid && Ack with no simultaneous publish -> Valid=0.
  - Publish in the same cycle as Ack -> new Ratio loaded, Valid stays 1, no Overrun.
  - Publish while Valid && !Ack -> Ratio overwritten, Overrun=1 (sticky until reset).
- Lock:
  - On each publish, if H equals the previous H, match count increments (saturating at LOCK_CNT); otherwise it resets to 1.
  - Locked = (match count >= LOCK_CNT).
  - Locked updates in the same cycle as Ratio.
- Width rules:
  - H ≥ 1 always; H=1 gives Ratio=0.
  - Minimum measurable H is 2, because a toggle every fast cycle aliases through the synchronizer.
  - Measurements with H=1 are not guaranteed.

Optional Feature:
- CLOCK_RATIO_METER_FULL_PERIOD_EN.
- Defined:
  - Only rising edges of the synchronized Slow_Clock terminate intervals; H = full period.
  - Ratio = H/2 − 1 (H shifted right by one, then decremented).
  - An odd H sets Ratio's published value as above and additionally pulses Ratio_Odd, an extra 1-bit output valid with Valid.
- Undefined:
  - Both edges terminate intervals, as described above.
  - The Ratio_Odd port is absent.

Decomposition:
- Shared package clock_pkg:
  - Constants: state encoding IDLE=2'd0, MEAS=2'd1, TOUT=2'd2; SYNC_STAGES=2; default CNT_W.
  - Function ratio_of(H) returning H−1.
- Sub-module clock_sync_edge: 2-flop synchronizer plus edge detector, outputs sync level and edge pulse.
- The top-level FSM, counter and handshake stay in clock_ratio_meter.

Test Plan:
- Slow_Clock toggling every 6 fast cycles, Ack tied 1:
  - First publish is at the second edge, with Ratio=5.
  - Valid pulses one cycle per edge; Locked=1 after the 2nd publish.
- Same stimulus, Ack=0:
  - First Ratio=5 is held and Valid stays 1.
  - At the next edge, Overrun=1 and Ratio=5.
  - Ack=1 then clears Valid.
- Period change from 6 to 10 cycles:
  - Ratio goes 5 then 9; Locked drops on the first 9.
  - Locked reasserts after the second consecutive 9.
- CNT_W=4, Slow_Clock stopped:
  - Timeout=1 once the counter reaches 15; Locked=0.
  - Restarting the toggles at every 6 cycles gives no publish at the first edge, Ratio=5 at the next.
- Reset=0 asserted for 1 cycle mid-interval, then released:
  - All outputs are 0.
  - No publish until two edges after release.
- With CLOCK_RATIO_METER_FULL_PERIOD_EN, full period 12:
  - Ratio=5, Ratio_Odd=0.
  - With full period 13: Ratio=5, Ratio_Odd=1.
